// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the IS25WP032D single-word read engine.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    RESP,
    GAP
  } spi_state_e;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         ADDR_W     = 24;
  localparam int         DATA_W     = 32;
  localparam int         FRAME_BITS = 64;

  // Bytes arrive first-byte-first; the first byte lands in the low lane.
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK generator: toggles every CLK_DIV enabled cycles, idles low, and flags
// the clk edges that will drive SCLK high (rise_stb) or low (fall_stb).
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] cnt;
  logic       tick;

  assign tick     = en && !clr && (cnt == DIV_M1);
  assign rise_stb = tick && !sclk;
  assign fall_stb = tick && sclk;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (cnt == DIV_M1) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Reads one 32-bit little-endian word from SPI flash (opcode 0x03, mode 0)
// per accepted request and returns it on a response handshake.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              SCLK,
  output logic              SCS,
  output logic              MOSI,
  input  logic              MISO,
  output spi_state_e        dbg_state
);

  localparam int         TX_W       = 8 + ADDR_W;
  localparam logic [5:0] CMD_LAST   = 6'd7;
  localparam logic [5:0] ADDR_LAST  = 6'(TX_W - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_BITS - 1);
  localparam logic [15:0] GAP_TGT   = 16'(CS_GAP);

  spi_state_e        state, next_state;
  logic [TX_W-1:0]   tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [5:0]        bit_cnt;
  logic [15:0]       gap_cnt;
  logic              busy, rise_stb, fall_stb, accept, frame_done;

  assign busy       = (state == CMD) || (state == ADDR) || (state == DATA);
  assign frame_done = (state == DATA) && fall_stb && (bit_cnt == FRAME_LAST);
  assign dbg_state  = state;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk      (clk),
    .reset    (reset),
    .en       (busy),
    .clr      (!busy),
    .sclk     (SCLK),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Both handshakes are plain valid/ready: a transfer happens on any edge where
  // valid && ready; the producer holds its payload stable until then.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        accept     = 1'b1;
        next_state = CMD;
      end
      CMD:  if (fall_stb && bit_cnt == CMD_LAST) next_state = ADDR;
      ADDR: if (fall_stb && bit_cnt == ADDR_LAST) next_state = DATA;
      DATA: if (frame_done) next_state = RESP;
      RESP: if (rsp_valid && rsp_ready) next_state = GAP;
      GAP:  if (gap_cnt >= GAP_TGT) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SCS       <= 1'b1;
      MOSI      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      req_ready <= (next_state == IDLE);
      if (accept) begin
        tx_sr   <= {CMD_READ, req_addr};
        MOSI    <= CMD_READ[7];
        SCS     <= 1'b0;
        rx_sr   <= '0;
        bit_cnt <= '0;
      end
      // Shift on the falling edge so MOSI only moves while SCLK is low; once the
      // command and address are out the register holds zeros for the data phase.
      if (busy && fall_stb) begin
        tx_sr   <= {tx_sr[TX_W-2:0], 1'b0};
        MOSI    <= tx_sr[TX_W-2];
        bit_cnt <= bit_cnt + 6'd1;
      end
      if (state == DATA && rise_stb) begin
        rx_sr <= {rx_sr[DATA_W-2:0], MISO};
      end
      if (frame_done) begin
        SCS       <= 1'b1;
        rsp_valid <= 1'b1;
        rsp_data  <= byte_swap(rx_sr);
        gap_cnt   <= 16'd1;
      end else if ((state == RESP || state == GAP) && gap_cnt != 16'hFFFF) begin
        gap_cnt <= gap_cnt + 16'd1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural IS25WP032D model, table of read
// vectors, and hand-written sequences for back-to-back and mid-frame reset.
module tb_spi_flash_reader;
  import spi_flash_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        SCLK, SCS, MOSI;
  logic        MISO = 1'b0;
  spi_state_e  dbg_state;

  spi_flash_reader #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .SCLK      (SCLK),
    .SCS       (SCS),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- flash model and line monitor ----------------
  // Sampled on the falling clk edge, where SCLK/SCS/MOSI are stable.
  logic [7:0]  mem [logic [21:0]];
  logic [31:0] fl_cmd = '0;
  int          fl_cnt = 0;
  logic        fl_sclk_q = 1'b0;
  logic [63:0] mosi_frame = '0;
  int          sclk_pulses = 0;
  int          scs_low_cnt = 0;
  int          scs_high_cnt = 0;
  int          k;
  logic [21:0] fa;
  logic [7:0]  fb;

  always @(negedge clk) begin
    if (SCS !== 1'b0) begin
      fl_cnt = 0;
      MISO = 1'($urandom_range(0, 1));
      scs_high_cnt++;
    end else begin
      scs_low_cnt++;
      if (SCLK === 1'b1 && fl_sclk_q === 1'b0) begin
        sclk_pulses++;
        mosi_frame = {mosi_frame[62:0], MOSI};
        if (fl_cnt < 32) begin
          fl_cmd = {fl_cmd[30:0], MOSI};
          MISO = 1'($urandom_range(0, 1));
        end
        fl_cnt++;
      end else if (SCLK === 1'b0 && fl_sclk_q === 1'b1 && fl_cnt >= 32 && fl_cnt < 64) begin
        k  = fl_cnt - 32;
        fa = fl_cmd[21:0] + 22'(k / 8);
        fb = mem.exists(fa) ? mem[fa] : 8'h00;
        MISO = fb[7 - (k % 8)];
      end
    end
    fl_sclk_q = SCLK;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got no event expected one", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic preload(input logic [23:0] addr, input logic [31:0] pre);
    logic [21:0] a;
    for (int j = 0; j < 4; j++) begin
      a = addr[21:0] + 22'(j);
      mem[a] = pre[31-8*j -: 8];
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [31:0] pre;      // bytes in flash order starting at addr, first in MSBs
    logic [31:0] exp;      // expected rsp_data
    int          hold;     // cycles rsp_ready stays low after rsp_valid
    int          exp_gap;  // edges from SCS rise to req_ready
  } vec_t;

  vec_t vecs [6];

  task automatic do_read(input vec_t v);
    bit ok;
    int n, p0, s0, e_rise;
    preload(v.addr, v.pre);
    wait_ready(ok);
    if (!ok) begin fail_timeout("req_ready"); return; end
    req_addr  = v.addr;
    req_valid = 1'b1;
    p0 = sclk_pulses;
    s0 = scs_low_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("scs low after accept", SCS, 0);
    check("mosi opcode bit7", MOSI, 0);
    check("req_ready low in frame", req_ready, 0);
    wait_rsp(n, ok);
    if (!ok) begin fail_timeout("rsp_valid"); return; end
    e_rise = cyc;
    // Edges after the accepting edge, plus the accept cycle itself.
    check("rsp latency", 64'(n + 1), 64'(128 * CLK_DIV + 1));
    check("rsp_data", rsp_data, v.exp);
    check("scs high at rsp", SCS, 1);
    check("sclk low at rsp", SCLK, 0);
    check("sclk pulses", 64'(sclk_pulses - p0), 64);
    check("scs low cycles", 64'(scs_low_cnt - s0), 256);
    check("mosi frame", mosi_frame, {8'h03, v.addr, 32'h0});
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      check("hold rsp_valid", rsp_valid, 1);
      check("hold rsp_data", rsp_data, v.exp);
      check("hold req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid after handshake", rsp_valid, 0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin fail_timeout("req_ready after gap"); return; end
    check("gap to req_ready", 64'(cyc - e_rise), 64'(v.exp_gap));
  endtask

  // ---------------- test ----------------
  initial begin
    bit ok;
    int n, hs0, rv;
    vec_t v0;

    vecs[0] = '{24'h000000, 32'h13000000, 32'h00000013, 0, 4};
    vecs[1] = '{24'h123456, 32'hDEADBEEF, 32'hEFBEADDE, 0, 4};
    vecs[2] = '{24'h3FFFFE, 32'hAABB1122, 32'h2211BBAA, 0, 4};
    vecs[3] = '{24'hA5A5A5, 32'h0180FF7E, 32'h7EFF8001, 10, 12};
    vecs[4] = '{24'hFFFFFF, 32'h5AC33CA5, 32'hA53CC35A, 0, 4};
    vecs[5] = '{24'h7FFFFD, 32'h01020304, 32'h04030201, 0, 4};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset scs", SCS, 1);
    check("reset sclk", SCLK, 0);
    check("reset mosi", MOSI, 0);
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("req_ready after reset", req_ready, 1);

    for (int i = 0; i < 6; i++) do_read(vecs[i]);

    // Back-to-back with req_valid held high
    preload(24'h000100, 32'h11223344);
    preload(24'h000104, 32'h55667788);
    req_addr  = 24'h000100;
    req_valid = 1'b1;
    wait_ready(ok);
    if (!ok) fail_timeout("b2b ready 1");
    @(posedge clk);
    #1;
    req_addr = 24'h000104;
    wait_rsp(n, ok);
    if (!ok) fail_timeout("b2b rsp 1");
    check("b2b word 1", rsp_data, 32'h44332211);
    hs0 = scs_high_cnt;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    wait_ready(ok);
    if (!ok) fail_timeout("b2b ready 2");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("b2b scs gap >= CS_GAP", 64'(scs_high_cnt - hs0 >= CS_GAP), 1);
    check("b2b scs low on 2nd", SCS, 0);
    wait_rsp(n, ok);
    if (!ok) fail_timeout("b2b rsp 2");
    check("b2b word 2", rsp_data, 32'h88776655);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset at cycle 100 of a frame
    preload(24'h000000, 32'h13000000);
    wait_ready(ok);
    if (!ok) fail_timeout("reset-frame ready");
    req_addr  = 24'h000000;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort scs", SCS, 1);
    check("abort sclk", SCLK, 0);
    check("abort mosi", MOSI, 0);
    check("abort rsp_valid", rsp_valid, 0);
    check("abort rsp_data", rsp_data, 0);
    check("abort state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk);
    #1;
    check("abort req_ready returns", req_ready, 1);
    rv = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (rsp_valid) rv++;
    end
    check("abort no rsp_valid", 64'(rv), 0);
    v0 = vecs[0];
    do_read(v0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
